// File: rtl/register_write_module_pkg.sv
// Shared opcode constants and FSM state encoding for the register/sprite-memory
// write engine. The host-side driver and the print datapath import these too.
package register_write_module_pkg;

  localparam logic [3:0] OP_WBR = 4'b0000;  // register-bank write
  localparam logic [3:0] OP_WSM = 4'b0001;  // sprite-memory write

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DECODE      = 3'd1,
    WAIT_SCREEN = 3'd2,
    WRITE_REG   = 3'd3,
    WRITE_MEM   = 3'd4,
    DONE        = 3'd5
  } state_e;

endpackage

// File: rtl/register_write_module.sv
// Instruction-driven write engine: accepts one instruction at a time, then
// issues a single write to either the register bank or the sprite memory.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  IDLE        | instr_ready high, waiting for instr_valid
//  DECODE      | operands latched, choose the write path
//  WAIT_SCREEN | register write held off while the display reads the bank
//  WRITE_REG   | reg_wr_en high for this cycle
//  WRITE_MEM   | mem_wr_en high for this cycle
//  DONE        | done pulse, return to IDLE
module register_write_module
  import register_write_module_pkg::*;
#(
  parameter int size_address = 14,
  parameter int size_reg     = 5,
  parameter int size_color   = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  input  logic [3:0]              opcode,
  input  logic [31:0]             dataA,
  input  logic [31:0]             dataB,
  input  logic                    printtingScreen,
  output logic                    instr_ready,
  output logic                    reg_wr_en,
  output logic [size_reg-1:0]     reg_address,
  output logic [31:0]             reg_data,
  output logic                    mem_wr_en,
  output logic [size_address-1:0] mem_address,
  output logic [size_color-1:0]   mem_data,
  output logic                    done,
  output logic                    illegal_op
);

  state_e                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [31:0]             a_q, a_d;
  logic [31:0]             b_q, b_d;
  logic                    reg_wr_en_q, reg_wr_en_d;
  logic [size_reg-1:0]     reg_address_q, reg_address_d;
  logic [31:0]             reg_data_q, reg_data_d;
  logic                    mem_wr_en_q, mem_wr_en_d;
  logic [size_address-1:0] mem_address_q, mem_address_d;
  logic [size_color-1:0]   mem_data_q, mem_data_d;
  logic                    done_q, done_d;
  logic                    illegal_op_q, illegal_op_d;

  // Next-state, operand latch and output register loads. Strobes and done are
  // loaded one cycle ahead so they are high exactly while in the target state.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    reg_wr_en_d   = 1'b0;
    reg_address_d = reg_address_q;
    reg_data_d    = reg_data_q;
    mem_wr_en_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    done_d        = 1'b0;
    illegal_op_d  = illegal_op_q;

    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          a_d     = dataA;
          b_d     = dataB;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (op_q == OP_WBR) begin
          if (printtingScreen) begin
            state_d = WAIT_SCREEN;
          end else begin
            reg_wr_en_d   = 1'b1;
            reg_address_d = a_q[size_reg-1:0];
            reg_data_d    = b_q;
            state_d       = WRITE_REG;
          end
        end else if (op_q == OP_WSM) begin
          // Sprite memory is dual-port, so no need to wait for the display.
          mem_wr_en_d   = 1'b1;
          mem_address_d = a_q[size_address-1:0];
          mem_data_d    = b_q[size_color-1:0];
          state_d       = WRITE_MEM;
        end else begin
          illegal_op_d = 1'b1;
          done_d       = 1'b1;
          state_d      = DONE;
        end
      end
      WAIT_SCREEN: begin
        if (!printtingScreen) begin
          reg_wr_en_d   = 1'b1;
          reg_address_d = a_q[size_reg-1:0];
          reg_data_d    = b_q;
          state_d       = WRITE_REG;
        end
      end
      WRITE_REG, WRITE_MEM: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_address_q <= '0;
      reg_data_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      done_q        <= 1'b0;
      illegal_op_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_address_q <= reg_address_d;
      reg_data_q    <= reg_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      done_q        <= done_d;
      illegal_op_q  <= illegal_op_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_address = reg_address_q;
  assign reg_data    = reg_data_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign done        = done_q;
  assign illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_register_write_module.sv
// Scoreboard bench for register_write_module: the stimulus pushes expected
// write/done events, the monitor pops and checks them as the DUT produces them.
module tb_register_write_module;
  import register_write_module_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [31:0] dataA, dataB;
  logic        printtingScreen;
  logic        instr_ready, reg_wr_en, mem_wr_en, done, illegal_op;
  logic [4:0]  reg_address;
  logic [31:0] reg_data;
  logic [13:0] mem_address;
  logic [8:0]  mem_data;

  register_write_module #(
    .size_address(14), .size_reg(5), .size_color(9)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .dataA(dataA), .dataB(dataB), .printtingScreen(printtingScreen),
    .instr_ready(instr_ready), .reg_wr_en(reg_wr_en), .reg_address(reg_address),
    .reg_data(reg_data), .mem_wr_en(mem_wr_en), .mem_address(mem_address),
    .mem_data(mem_data), .done(done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  localparam int K_REG  = 0;
  localparam int K_MEM  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ill;
    logic [31:0] lra, lrd, lma, lmd;
  } ev_t;

  ev_t q[$];
  logic        exp_ill;
  logic [31:0] last_ra, last_rd, last_ma, last_md;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_done(input int c);
    ev_t e;
    e.kind = K_DONE; e.cyc = c; e.addr = '0; e.data = '0; e.ill = exp_ill;
    e.lra = last_ra; e.lrd = last_rd; e.lma = last_ma; e.lmd = last_md;
    q.push_back(e);
  endtask

  task automatic push_reg(input int c, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    last_ra = {27'b0, a[4:0]};
    last_rd = b;
    e.kind = K_REG; e.cyc = c; e.addr = last_ra; e.data = last_rd; e.ill = exp_ill;
    e.lra = '0; e.lrd = '0; e.lma = '0; e.lmd = '0;
    q.push_back(e);
    push_done(c + 1);
  endtask

  task automatic push_mem(input int c, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    last_ma = {18'b0, a[13:0]};
    last_md = {23'b0, b[8:0]};
    e.kind = K_MEM; e.cyc = c; e.addr = last_ma; e.data = last_md; e.ill = exp_ill;
    e.lra = '0; e.lrd = '0; e.lma = '0; e.lmd = '0;
    q.push_back(e);
    push_done(c + 1);
  endtask

  task automatic take(input int k);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", k, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (k == K_REG) begin
        chk("reg_address", {27'b0, reg_address}, e.addr);
        chk("reg_data", reg_data, e.data);
      end else if (k == K_MEM) begin
        chk("mem_address", {18'b0, mem_address}, e.addr);
        chk("mem_data", {23'b0, mem_data}, e.data);
      end else begin
        chk("done_illegal_op", {31'b0, illegal_op}, {31'b0, e.ill});
        chk("hold_reg_address", {27'b0, reg_address}, e.lra);
        chk("hold_reg_data", reg_data, e.lrd);
        chk("hold_mem_address", {18'b0, mem_address}, e.lma);
        chk("hold_mem_data", {23'b0, mem_data}, e.lmd);
      end
    end
  endtask

  // Monitor: checks strobe exclusivity and consumes expected events.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("dual_strobe", {31'b0, reg_wr_en & mem_wr_en}, 32'd0);
      if (reg_wr_en) take(K_REG);
      if (mem_wr_en) take(K_MEM);
      if (done)      take(K_DONE);
    end
  end

  // Issue one instruction; hs is the cycle index of the DECODE cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit stall, input bit hold, output int hs);
    int i;
    @(negedge clk);
    opcode = op; dataA = a; dataB = b; instr_valid = 1'b1;
    i = 0;
    while (!instr_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (!instr_ready) begin
      chk("handshake_timeout", {31'b0, instr_ready}, 32'd1);
      instr_valid = 1'b0;
      hs = -1;
    end else begin
      @(posedge clk);
      #1;
      hs = cyc;
      if (!stall) begin
        if (op == OP_WBR)      push_reg(hs + 1, a, b);
        else if (op == OP_WSM) push_mem(hs + 1, a, b);
        else begin
          exp_ill = 1'b1;
          push_done(hs + 1);
        end
      end
      if (!hold) begin
        instr_valid = 1'b0;
        opcode = op ^ 4'h1;
        dataA = ~a;
        dataB = ~b;
      end
    end
  endtask

  int hs0, hs1, hs2, hs3, r;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; opcode = '0; dataA = '0; dataB = '0;
    printtingScreen = 1'b0;
    exp_ill = 1'b0; last_ra = '0; last_rd = '0; last_ma = '0; last_md = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_reg_wr_en", {31'b0, reg_wr_en}, 32'd0);
    chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_illegal_op", {31'b0, illegal_op}, 32'd0);
    chk("rst_reg_data", reg_data, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;

    // Plain register write: strobe at DECODE+1, done at DECODE+2.
    issue(OP_WBR, 32'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, hs0);
    // Sprite write with upper operand bits set.
    issue(OP_WSM, 32'h0001_3FFF, 32'h0000_01FF, 1'b0, 1'b0, hs0);
    issue(OP_WSM, 32'hFFFF_0005, 32'hFFFF_FE00, 1'b0, 1'b0, hs0);

    // Register write stalled by the display for 10 cycles.
    printtingScreen = 1'b1;
    issue(OP_WBR, 32'd5, 32'hCAFE_F00D, 1'b1, 1'b0, hs0);
    repeat (10) @(negedge clk);
    printtingScreen = 1'b0;
    push_reg(cyc + 1, 32'd5, 32'hCAFE_F00D);

    // Illegal opcode, then a legal write with the sticky flag still set.
    issue(4'hF, 32'd1, 32'd2, 1'b0, 1'b0, hs0);
    issue(OP_WBR, 32'h0000_003F, 32'h1234_5678, 1'b0, 1'b0, hs0);
    chk("illegal_sticky", {31'b0, illegal_op}, 32'd1);

    // Back-to-back sprite writes with instr_valid held high.
    issue(OP_WSM, 32'd10, 32'd11, 1'b0, 1'b1, hs1);
    issue(OP_WSM, 32'd20, 32'd22, 1'b0, 1'b1, hs2);
    issue(OP_WSM, 32'd30, 32'd33, 1'b0, 1'b1, hs3);
    instr_valid = 1'b0;
    chk("b2b_interval_1", hs2 - hs1, 32'd4);
    chk("b2b_interval_2", hs3 - hs2, 32'd4);
    repeat (4) @(negedge clk);

    // Reset while stalled in WAIT_SCREEN: the aborted write must never appear.
    printtingScreen = 1'b1;
    issue(OP_WBR, 32'd7, 32'h0000_0BAD, 1'b1, 1'b0, hs0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_ill = 1'b0; last_ra = '0; last_rd = '0; last_ma = '0; last_md = '0;
    chk("abort_instr_ready", {31'b0, instr_ready}, 32'd1);
    chk("abort_reg_wr_en", {31'b0, reg_wr_en}, 32'd0);
    chk("abort_reg_address", {27'b0, reg_address}, 32'd0);
    chk("abort_reg_data", reg_data, 32'd0);
    chk("abort_mem_address", {18'b0, mem_address}, 32'd0);
    chk("abort_mem_data", {23'b0, mem_data}, 32'd0);
    chk("abort_illegal_op", {31'b0, illegal_op}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    printtingScreen = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    r = cyc;
    opcode = OP_WBR; dataA = 32'd9; dataB = 32'h0F0F_0F0F; instr_valid = 1'b1;
    @(posedge clk);
    #1;
    hs0 = cyc;
    instr_valid = 1'b0;
    chk("post_reset_accept", hs0, r + 1);
    push_reg(hs0 + 1, 32'd9, 32'h0F0F_0F0F);

    repeat (8) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
